// File: rtl/sm_regdump.sv
// Debug-port reader for sm_cpu: walks regAddr 0..31 and streams each register
// as a 5-byte record {addr, data[31:24..7:0]} over a UART 8N1 transmit line.
module sm_regdump #(
   parameter int BAUD_DIV = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SEND} state_t;

   state_t        state, state_nx;
   logic [BW-1:0] baud_cnt, baud_cnt_nx;
   logic [3:0]    bit_cnt, bit_cnt_nx;
   logic [2:0]    byte_cnt, byte_cnt_nx;
   logic [31:0]   hold, hold_nx;
   logic [4:0]    addr_nx;
   logic          tx_nx, busy_nx, done_nx;
   logic [7:0]    cur_byte;

   always_comb begin
      case (byte_cnt)
         3'd0:    cur_byte = {3'b000, regAddr};
         3'd1:    cur_byte = hold[31:24];
         3'd2:    cur_byte = hold[23:16];
         3'd3:    cur_byte = hold[15:8];
         default: cur_byte = hold[7:0];
      endcase
   end

   always_comb begin
      // NOTE: every next value is defaulted first so no path can infer a latch.
      state_nx    = state;
      baud_cnt_nx = baud_cnt;
      bit_cnt_nx  = bit_cnt;
      byte_cnt_nx = byte_cnt;
      hold_nx     = hold;
      addr_nx     = regAddr;
      tx_nx       = tx;
      busy_nx     = busy;
      done_nx     = 1'b0;

      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (start) begin
               state_nx = SETTLE;
               addr_nx  = 5'd0;
               busy_nx  = 1'b1;
            end
         end
         SETTLE: begin
            state_nx    = SEND;
            hold_nx     = regData;
            baud_cnt_nx = '0;
            bit_cnt_nx  = 4'd0;
            byte_cnt_nx = 3'd0;
            tx_nx       = 1'b0;
         end
         SEND: begin
            if (baud_cnt != BAUD_LAST) begin
               baud_cnt_nx = baud_cnt + 1'b1;
            end else begin
               baud_cnt_nx = '0;
               if (bit_cnt != 4'd9) begin
                  // tx is registered, so load the value of the bit about to start
                  bit_cnt_nx = bit_cnt + 4'd1;
                  tx_nx      = (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
               end else if (byte_cnt != 3'd4) begin
                  bit_cnt_nx  = 4'd0;
                  byte_cnt_nx = byte_cnt + 3'd1;
                  tx_nx       = 1'b0;
               end else if (regAddr != 5'd31) begin
                  state_nx = SETTLE;
                  addr_nx  = regAddr + 5'd1;
                  tx_nx    = 1'b1;
               end else begin
                  state_nx = IDLE;
                  addr_nx  = 5'd0;
                  busy_nx  = 1'b0;
                  done_nx  = 1'b1;
                  tx_nx    = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= 4'd0;
         byte_cnt <= 3'd0;
         hold     <= 32'd0;
         regAddr  <= 5'd0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_cnt_nx;
         bit_cnt  <= bit_cnt_nx;
         byte_cnt <= byte_cnt_nx;
         hold     <= hold_nx;
         regAddr  <= addr_nx;
         tx       <= tx_nx;
         busy     <= busy_nx;
         done     <= done_nx;
      end
   end

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump at BAUD_DIV=4 with a background UART decoder
// and a combinational register-file model behind regData.
module tb_sm_regdump;
   localparam int BD   = 4;
   localparam int REC  = 50 * BD + 1;
   localparam int DUMP = 32 * REC;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic        tx, busy, done;

   logic [31:0] regs     [32];
   logic [31:0] exp_regs [32];
   logic [7:0]  rx_q [$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [9:0] dec_bits;
   bit         dec_ok, dec_abort;

   sm_regdump #(.BAUD_DIV(BD)) dut (
      .clk(clk), .rst(rst), .start(start), .regAddr(reg_addr),
      .regData(reg_data), .tx(tx), .busy(busy), .done(done)
   );

   assign reg_data = regs[reg_addr];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART decoder: samples every cycle on negedge, requires each bit flat for BD cycles
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            dec_ok    = 1'b1;
            dec_abort = 1'b0;
            for (int c = 0; c < 10 * BD; c++) begin
               if (c > 0) @(negedge clk);
               if (rst) begin
                  dec_abort = 1'b1;
                  break;
               end
               if (c % BD == 0) dec_bits[c / BD] = tx;
               else if (tx !== dec_bits[c / BD]) dec_ok = 1'b0;
            end
            if (!dec_abort) begin
               checks++;
               if (!dec_ok || dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1) begin
                  errors++;
                  $display("FAIL uart_frame at cyc %0d: bits=%b flat=%0d, required start=0 stop=1 flat=1",
                           cyc, dec_bits, dec_ok);
               end
               rx_q.push_back(dec_bits[8:1]);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_default();
      for (int a = 0; a < 32; a++) regs[a] = 32'(a) * 32'h0101_0101;
   endtask

   task automatic do_start(output int t0);
      start = 1'b1;
      step(1);
      start = 1'b0;
      t0 = cyc;
   endtask

   // Steps until done is seen (bounded); reports done edge, and cycles where busy was low beforehand
   task automatic run_dump(output int done_at, output int busy_gaps);
      done_at   = -1;
      busy_gaps = 0;
      for (int i = 0; i < DUMP + 100; i++) begin
         step(1);
         if (done === 1'b1) begin
            done_at = cyc;
            break;
         end
         if (busy !== 1'b1) busy_gaps++;
      end
   endtask

   function automatic logic [39:0] exp_rec(input int n);
      logic [4:0] a;
      a = n[4:0];
      return {3'b000, a, exp_regs[a]};
   endfunction

   function automatic logic [39:0] got_rec(input int n);
      return {rx_q[5*n], rx_q[5*n+1], rx_q[5*n+2], rx_q[5*n+3], rx_q[5*n+4]};
   endfunction

   task automatic test_reset();
      int t0, activity;
      rst = 1'b1;
      start = 1'b0;
      fill_default();
      step(3);
      checks++;
      if ({tx, busy, done, reg_addr} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL reset_init: tx/busy/done/addr=%b/%b/%b/%0d, required 1/0/0/0", tx, busy, done, reg_addr);
      end
      rst = 1'b0;
      step(1);
      do_start(t0);
      step(10);
      rst = 1'b1;
      step(1);
      checks++;
      if ({tx, busy, done, reg_addr} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL reset_mid: tx/busy/done/addr=%b/%b/%b/%0d, required 1/0/0/0", tx, busy, done, reg_addr);
      end
      step(2);
      rst = 1'b0;
      activity = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) activity++;
      end
      checks++;
      if (activity != 0) begin
         errors++;
         $display("FAIL reset_quiet: %0d active cycles after reset, required 0", activity);
      end
      rx_q.delete();
   endtask

   task automatic test_single_record();
      int t0;
      fill_default();
      regs[0] = 32'h0000_0010;
      exp_regs = regs;
      rx_q.delete();
      do_start(t0);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_settle: tx=%b busy=%b at T, required tx=1 busy=1", tx, busy);
      end
      step(1);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL single_startbit: tx=%b at T+1, required 0", tx);
      end
      step(REC);
      checks++;
      if (rx_q.size() != 5) begin
         errors++;
         $display("FAIL single_count: %0d bytes after record 0, required 5", rx_q.size());
      end else if (got_rec(0) !== 40'h00_0000_0010) begin
         errors++;
         $display("FAIL single_bytes: got %h, required 0000000010", got_rec(0));
      end
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      rx_q.delete();
   endtask

   task automatic test_full_dump();
      int t0, done_at, gaps, extra;
      fill_default();
      regs[5] = 32'h1234_5678;
      exp_regs = regs;
      rx_q.delete();
      do_start(t0);
      run_dump(done_at, gaps);
      checks++;
      if (done_at != t0 + DUMP || gaps != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_timing: done at T+%0d busy_gaps=%0d busy_at_done=%b, required T+%0d 0 0",
                  done_at - t0, gaps, busy, DUMP);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL full_after: %0d bad cycles after done, required 0", extra);
      end
      checks++;
      if (rx_q.size() != 160) begin
         errors++;
         $display("FAIL full_count: %0d bytes, required 160", rx_q.size());
      end else begin
         for (int n = 0; n < 32; n++) begin
            checks++;
            if (got_rec(n) !== exp_rec(n)) begin
               errors++;
               $display("FAIL full_rec%0d: got %h, required %h", n, got_rec(n), exp_rec(n));
            end
         end
      end
   endtask

   task automatic test_data_stability();
      int t0, done_at, gaps;
      fill_default();
      regs[3] = 32'hAABB_CCDD;
      exp_regs = regs;
      rx_q.delete();
      do_start(t0);
      step(1 + 3 * REC + 10 - 1);
      regs[3] = 32'h1122_3344;
      run_dump(done_at, gaps);
      checks++;
      if (done_at != t0 + DUMP) begin
         errors++;
         $display("FAIL stab_timing: done at T+%0d, required T+%0d", done_at - t0, DUMP);
      end
      checks++;
      if (rx_q.size() != 160) begin
         errors++;
         $display("FAIL stab_count: %0d bytes, required 160", rx_q.size());
      end else if (got_rec(3) !== exp_rec(3)) begin
         errors++;
         $display("FAIL stab_rec3: got %h, required %h", got_rec(3), exp_rec(3));
      end
      step(3);
   endtask

   task automatic test_start_while_busy();
      int t0, done_at, gaps, bad;
      fill_default();
      exp_regs = regs;
      rx_q.delete();
      do_start(t0);
      step(99);
      start = 1'b1;
      step(1);
      start = 1'b0;
      run_dump(done_at, gaps);
      checks++;
      if (done_at != t0 + DUMP || gaps != 0) begin
         errors++;
         $display("FAIL busy_timing: done at T+%0d gaps=%0d, required T+%0d 0", done_at - t0, gaps, DUMP);
      end
      step(3);
      bad = 0;
      for (int n = 0; n < 32 && rx_q.size() == 160; n++)
         if (got_rec(n) !== exp_rec(n)) bad++;
      checks++;
      if (rx_q.size() != 160 || bad != 0) begin
         errors++;
         $display("FAIL busy_records: %0d bytes %0d bad records, required 160 0", rx_q.size(), bad);
      end
   endtask

   task automatic test_back_to_back();
      int t0, done1, done2, gaps1, gaps2, bad;
      fill_default();
      exp_regs = regs;
      rx_q.delete();
      start = 1'b1;
      step(1);
      t0 = cyc;
      run_dump(done1, gaps1);
      checks++;
      if (done1 != t0 + DUMP) begin
         errors++;
         $display("FAIL b2b_done1: done at T+%0d, required T+%0d", done1 - t0, DUMP);
      end
      step(1);
      checks++;
      if ({busy, done, tx, reg_addr} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL b2b_restart: busy/done/tx/addr=%b/%b/%b/%0d, required 1/0/1/0", busy, done, tx, reg_addr);
      end
      run_dump(done2, gaps2);
      start = 1'b0;
      checks++;
      if (done2 != t0 + 2 * DUMP + 1 || gaps1 != 0 || gaps2 != 0) begin
         errors++;
         $display("FAIL b2b_done2: done at T+%0d gaps=%0d/%0d, required T+%0d 0/0",
                  done2 - t0, gaps1, gaps2, 2 * DUMP + 1);
      end
      step(5);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: busy=%b tx=%b after release, required 0 1", busy, tx);
      end
      bad = 0;
      for (int n = 0; n < 64 && rx_q.size() == 320; n++)
         if (got_rec(n) !== exp_rec(n % 32)) bad++;
      checks++;
      if (rx_q.size() != 320 || bad != 0) begin
         errors++;
         $display("FAIL b2b_records: %0d bytes %0d bad records, required 320 0", rx_q.size(), bad);
      end
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_full_dump();
      test_data_stability();
      test_start_while_busy();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
